// File: rtl/seq_shifter_if.sv
// Handshake and data bundle between the control unit (master) and the
// multi-cycle shift unit (slave).
interface seq_shifter_if #(
  parameter int WIDTH = 32
);
  localparam int SW = $clog2(WIDTH);

  logic             start;
  logic [2:0]       op;
  logic [SW-1:0]    amt;
  logic [WIDTH-1:0] in;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] out;
  logic             carry;
  logic             zero;

  modport master (
    output start, op, amt, in,
    input  ready, busy, done, out, carry, zero
  );

  modport slave (
    input  start, op, amt, in,
    output ready, busy, done, out, carry, zero
  );
endinterface

// File: rtl/seq_shifter.sv
// Multi-cycle shift unit: logical, arithmetic and rotate shifts at one bit per
// clock under a start/done handshake, with carry-out and zero flags.
module seq_shifter #(
  parameter int WIDTH = 32
) (
  input  logic          clk,
  input  logic          rst,
  seq_shifter_if.slave  bus
);
  localparam int SW = $clog2(WIDTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [2:0] OP_LSR = 3'b001;
  localparam logic [2:0] OP_LSL = 3'b010;
  localparam logic [2:0] OP_ROR = 3'b011;
  localparam logic [2:0] OP_ROL = 3'b100;
  localparam logic [2:0] OP_ASR = 3'b101;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             carry_q, carry_d;
  logic             zero_q, zero_d;
  logic [2:0]       op_q, op_d;
  logic [SW-1:0]    cnt_q, cnt_d;

  logic             accept;
  logic             pass_req;
  logic [WIDTH-1:0] shifted;
  logic             shift_bit;

  // One-bit step of the latched operation; shift_bit is the bit that leaves.
  always_comb begin
    shifted   = out_q;
    shift_bit = 1'b0;
    case (op_q)
      OP_LSR: begin
        shifted   = {1'b0, out_q[WIDTH-1:1]};
        shift_bit = out_q[0];
      end
      OP_LSL: begin
        shifted   = {out_q[WIDTH-2:0], 1'b0};
        shift_bit = out_q[WIDTH-1];
      end
      OP_ROR: begin
        shifted   = {out_q[0], out_q[WIDTH-1:1]};
        shift_bit = out_q[0];
      end
      OP_ROL: begin
        shifted   = {out_q[WIDTH-2:0], out_q[WIDTH-1]};
        shift_bit = out_q[WIDTH-1];
      end
      OP_ASR: begin
        shifted   = {out_q[WIDTH-1], out_q[WIDTH-1:1]};
        shift_bit = out_q[0];
      end
      default: begin
        shifted   = out_q;
        shift_bit = 1'b0;
      end
    endcase
  end

  always_comb begin
    state_d  = state_q;
    out_d    = out_q;
    carry_d  = carry_q;
    zero_d   = zero_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    accept   = bus.start && (state_q != S_SHIFT);
    pass_req = (bus.op == 3'b000) || (bus.op == 3'b110) || (bus.op == 3'b111);

    case (state_q)
      S_SHIFT: begin
        out_d   = shifted;
        carry_d = shift_bit;
        cnt_d   = cnt_q - SW'(1);
        if (cnt_q == SW'(1)) begin
          state_d = S_DONE;
          zero_d  = (shifted == '0);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // A new request in IDLE or DONE overrides the default transition, which
    // is what allows back-to-back issue straight out of DONE.
    if (accept) begin
      out_d   = bus.in;
      op_d    = bus.op;
      cnt_d   = bus.amt;
      carry_d = 1'b0;
      if (pass_req || (bus.amt == '0)) begin
        state_d = S_DONE;
        zero_d  = (bus.in == '0);
      end else begin
        state_d = S_SHIFT;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      out_q   <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
      op_q    <= 3'b000;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      carry_q <= carry_d;
      zero_q  <= zero_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.ready = (state_q != S_SHIFT);
  assign bus.busy  = (state_q == S_SHIFT);
  assign bus.done  = (state_q == S_DONE);
  assign bus.out   = out_q;
  assign bus.carry = carry_q;
  assign bus.zero  = zero_q;
endmodule

// File: tb/tb_seq_shifter.sv
// Self-checking bench for seq_shifter: directed scenarios with literal results
// plus randomized traffic compared every cycle against an arithmetic model.
module tb_seq_shifter;
  localparam int W  = 32;
  localparam int SW = $clog2(W);

  logic clk = 1'b0;
  logic rst = 1'b1;

  seq_shifter_if #(.WIDTH(W)) bus();

  seq_shifter #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Model state: edge count, accept/completion edges, and visible results.
  int           n = 0;
  int           a_edge = 0;
  int           d_edge = 0;
  int           k_amt;
  bit           active = 1'b0;
  bit           m_rdy;
  logic [W-1:0] p_out, m_out = '0;
  logic         p_carry, m_carry = 1'b0, m_zero = 1'b0;

  task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Whole-operation result computed with plain shifts on the full operand.
  function automatic void model_op(input logic [2:0] o, input int k, input logic [W-1:0] x,
                                   output logic [W-1:0] r, output logic c);
    r = x;
    c = 1'b0;
    if (k == 0) return;
    case (o)
      3'd1: begin r = x >> k; c = x[k-1]; end
      3'd2: begin r = x << k; c = x[W-k]; end
      3'd3: begin r = (x >> k) | (x << (W - k)); c = x[k-1]; end
      3'd4: begin r = (x << k) | (x >> (W - k)); c = x[W-k]; end
      3'd5: begin r = $signed(x) >>> k; c = x[k-1]; end
      default: begin r = x; c = 1'b0; end
    endcase
  endfunction

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        n = 0; active = 1'b0;
        m_out = '0; m_carry = 1'b0; m_zero = 1'b0;
      end else begin
        m_rdy = !(active && n >= a_edge && n < d_edge);
        n++;
        if (bus.start && m_rdy) begin
          k_amt  = (bus.op >= 3'd1 && bus.op <= 3'd5) ? int'(bus.amt) : 0;
          active = 1'b1;
          a_edge = n;
          d_edge = n + k_amt;
          model_op(bus.op, k_amt, bus.in, p_out, p_carry);
        end
        if (active && n == d_edge) begin
          m_out = p_out; m_carry = p_carry; m_zero = (p_out == '0);
        end
      end
    end
  end

  initial begin
    bit eb, ed;
    forever begin
      @(negedge clk); #2;
      eb = active && n >= a_edge && n < d_edge;
      ed = active && n == d_edge;
      checkOutput("cyc_ready", bus.ready, !eb);
      checkOutput("cyc_busy",  bus.busy,  eb);
      checkOutput("cyc_done",  bus.done,  ed);
      if (!eb) begin
        checkOutput("cyc_out",   bus.out,   m_out);
        checkOutput("cyc_carry", bus.carry, m_carry);
        checkOutput("cyc_zero",  bus.zero,  m_zero);
      end
    end
  end

  task automatic applyStimulus(input logic [2:0] o, input int k, input logic [W-1:0] x);
    bus.start = 1'b1;
    bus.op    = o;
    bus.amt   = SW'(k);
    bus.in    = x;
    @(negedge clk); #1;
    bus.start = 1'b0;
    bus.op    = 3'($urandom);
    bus.amt   = SW'($urandom);
    bus.in    = $urandom;
  endtask

  task automatic waitDone(output int bc);
    int guard = 0;
    bc = 0;
    while (bus.done !== 1'b1 && guard < 64) begin
      if (bus.busy === 1'b1) bc++;
      @(negedge clk); #1;
      guard++;
    end
    tests++;
    if (guard >= 64) begin
      fails++;
      $display("[TB] FAIL done_timeout: got no done after %0d cycles, expected done", guard);
    end
  endtask

  initial begin
    int           bc;
    logic [W-1:0] r;
    logic         c;

    bus.start = 1'b0; bus.op = 3'b000; bus.amt = '0; bus.in = '0;

    model_op(3'd5, 4, 32'h8000_0000, r, c);
    checkOutput("model_asr", r, 32'hF800_0000);
    checkOutput("model_asr_c", c, 0);
    model_op(3'd3, 1, 32'h0000_0001, r, c);
    checkOutput("model_ror", r, 32'h8000_0000);
    checkOutput("model_ror_c", c, 1);
    model_op(3'd4, 1, 32'h8000_0000, r, c);
    checkOutput("model_rol", r, 32'h0000_0001);
    model_op(3'd2, 16, 32'h0000_FFFF, r, c);
    checkOutput("model_lsl", r, 32'hFFFF_0000);

    repeat (2) @(negedge clk);
    #1;
    checkOutput("rst_out", bus.out, 0);
    checkOutput("rst_flags", {bus.ready, bus.busy, bus.done, bus.carry, bus.zero}, 5'b10000);
    rst = 1'b0;
    @(negedge clk); #1;

    applyStimulus(3'b101, 4, 32'h8000_0000);
    waitDone(bc);
    checkOutput("asr_busy", bc, 4);
    checkOutput("asr_out", bus.out, 32'hF800_0000);
    checkOutput("asr_cz", {bus.carry, bus.zero}, 2'b00);
    @(negedge clk); #1;

    applyStimulus(3'b011, 1, 32'h0000_0001);
    waitDone(bc);
    checkOutput("ror_busy", bc, 1);
    checkOutput("ror_out", bus.out, 32'h8000_0000);
    checkOutput("ror_carry", bus.carry, 1);
    @(negedge clk); #1;

    applyStimulus(3'b010, 16, 32'h0000_FFFF);
    waitDone(bc);
    checkOutput("lsl_busy", bc, 16);
    checkOutput("lsl_out", bus.out, 32'hFFFF_0000);
    checkOutput("lsl_carry", bus.carry, 0);
    applyStimulus(3'b001, 2, 32'h0000_0003);
    waitDone(bc);
    checkOutput("b2b_busy", bc, 2);
    checkOutput("b2b_out", bus.out, 32'h0000_0000);
    checkOutput("b2b_cz", {bus.carry, bus.zero}, 2'b11);
    @(negedge clk); #1;

    applyStimulus(3'b000, 7, 32'h1234_5678);
    waitDone(bc);
    checkOutput("pass_busy", bc, 0);
    checkOutput("pass_out", bus.out, 32'h1234_5678);
    checkOutput("pass_carry", bus.carry, 0);
    @(negedge clk); #1;
    applyStimulus(3'b001, 0, 32'h1234_5678);
    waitDone(bc);
    checkOutput("amt0_busy", bc, 0);
    checkOutput("amt0_out", bus.out, 32'h1234_5678);
    checkOutput("amt0_carry", bus.carry, 0);
    @(negedge clk); #1;

    applyStimulus(3'b001, 8, 32'hFF00_0000);
    @(negedge clk); #1;
    bus.start = 1'b1; bus.op = 3'b100; bus.amt = SW'(3); bus.in = 32'hDEAD_BEEF;
    @(negedge clk); #1;
    bus.start = 1'b0;
    waitDone(bc);
    checkOutput("ign_busy", bc + 2, 8);
    checkOutput("ign_out", bus.out, 32'h00FF_0000);
    @(negedge clk); #1;

    applyStimulus(3'b100, 20, 32'hA5A5_0F0F);
    repeat (5) begin @(negedge clk); #1; end
    rst = 1'b1;
    #1;
    checkOutput("arst_out", bus.out, 0);
    checkOutput("arst_flags", {bus.ready, bus.busy, bus.done}, 3'b100);
    @(negedge clk); #1;
    rst = 1'b0;
    @(negedge clk); #1;
    applyStimulus(3'b100, 1, 32'h8000_0000);
    waitDone(bc);
    checkOutput("post_rst_out", bus.out, 32'h0000_0001);
    checkOutput("post_rst_carry", bus.carry, 1);
    @(negedge clk); #1;

    for (int i = 0; i < 600; i++) begin
      if (rst) rst = 1'b0;
      else if ($urandom_range(0, 149) == 0) rst = 1'b1;
      bus.start = ($urandom_range(0, 2) == 0);
      bus.op    = 3'($urandom);
      bus.amt   = ($urandom_range(0, 3) == 0) ? SW'($urandom_range(0, 2)) : SW'($urandom);
      case ($urandom_range(0, 3))
        0:       bus.in = '0;
        1:       bus.in = 32'h8000_0000 | $urandom_range(0, 15);
        default: bus.in = $urandom;
      endcase
      @(negedge clk); #1;
    end

    rst = 1'b0;
    bus.start = 1'b0;
    repeat (40) @(negedge clk);
    #3;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/seq_shifter.md
Name: seq_shifter

Overview:
Multi-cycle, parametrised shift unit for the datapath. It replaces the fixed one-bit and sixteen-bit combinational shifts with variable-amount logical, arithmetic and rotate operations. It shifts one bit per clock under a start/done handshake and reports carry-out and zero flags. It sits between the register-file read bus and the ALU result mux, driven by the control unit.

Parameters:
WIDTH, 32, data width in bits; must be a power of two and at least 4.
SW, $clog2(WIDTH), width of the shift-amount port; derived, never overridden.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst  input  1  reset; asynchronous, active-high.
start  input  1  request; sampled only when ready=1.
op  input  3  operation code (see Behaviour).
amt  input  SW  shift amount, 0..WIDTH-1.
in  input  WIDTH  operand.
ready  output  1  unit can accept start this cycle.
busy  output  1  a shift is in progress.
done  output  1  one-cycle pulse; out/carry/zero are valid.
out  output  WIDTH  result register.
carry  output  1  last bit shifted or rotated out; 0 if no bit moved.
zero  output  1  out == 0; valid while done=1, held afterwards.

Behaviour:
- Opcodes:
  - 000 pass
  - 001 LSR (zero fill)
  - 010 LSL (zero fill)
  - 011 ROR
  - 100 ROL
  - 101 ASR (MSB replicated)
  - 110 and 111 behave as pass.
- Reset (asynchronous): state=IDLE, out=0, carry=0, zero=0, done=0, busy=0, internal counter=0. Reset mid-shift aborts the operation immediately; no done pulse is produced.
- States: IDLE, SHIFT, DONE.
  - ready = (state != SHIFT).
  - busy = (state == SHIFT).
  - done = (state == DONE).
- Accept: at a rising edge with start=1 and ready=1:
  - Latch in→out, op, amt→cnt; clear carry.
  - If amt==0 or op is a pass code, go to DONE.
  - Otherwise go to SHIFT.
- SHIFT, each edge:
  - Shift out by one bit per op.
  - carry ← the bit leaving (bit0 for LSR/ROR/ASR, bit WIDTH-1 for LSL/ROL).
  - cnt ← cnt-1.
  - When cnt==1 at the edge, perform the final shift and go to DONE.
- DONE:
  - done=1 for exactly one cycle.
  - zero is computed from the final out and registered on entry to DONE.
  - Next edge: go to IDLE, or accept a new start (back-to-back issue allowed, with no bubble).
- Latency: done is high in the cycle following the edge that completes the last shift.
  - amt=N>0 gives done N cycles after the accept edge.
  - amt=0 or pass gives done 1 cycle after the accept edge.
- Start while busy=1 is ignored: no queuing, no effect on in-flight operands.
- in, op and amt may change freely after acceptance; only the latched copies are used.
- out holds its value in IDLE until the next accept. carry and zero also hold.
- Rotates preserve all bits. ROR/ROL by k equal ROL/ROR by WIDTH-k.
- amt never exceeds WIDTH-1 by construction; no overflow handling is required.

Test Plan (WIDTH=32):
- ASR: in=0x80000000, op=101, amt=4, start pulse → busy for 4 cycles; done pulse with out=0xF8000000, carry=0, zero=0.
- ROR: in=0x00000001, op=011, amt=1 → done 1 cycle after accept; out=0x80000000, carry=1.
- LSL: in=0x0000FFFF, op=010, amt=16 → done 16 cycles after accept; out=0xFFFF0000, carry=0. Then LSR in=0x00000003, amt=2 issued in the DONE cycle (back-to-back) → out=0x00000000, carry=1, zero=1.
- Pass and amt=0: op=000 with in=0x12345678 amt=7, then op=001 amt=0 → each gives done 1 cycle after accept; out=0x12345678, carry=0.
- Ignored start: issue LSR amt=8 on 0xFF000000; pulse start with different operands at cycle 3 → ignored; done at cycle 8 with out=0x00FF0000.
- Async reset: assert rst between clock edges during an amt=20 ROL → out=0, busy=0, done=0, ready=1 immediately. After deassert, a new op=100 in=0x80000000 amt=1 → out=0x00000001, carry=1.
